// File: rtl/mips_register_file_if.sv
// mips_register_file_if: read/write port bundle between the datapath and the register file
interface mips_register_file_if;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        reg_write;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    modport master (
        output read_reg1, read_reg2, write_reg, write_data, reg_write,
        input  read_data1, read_data2
    );
    modport slave (
        input  read_reg1, read_reg2, write_reg, write_data, reg_write,
        output read_data1, read_data2
    );
endinterface

// File: rtl/mips_register_file.sv
// mips_register_file: 32x32 register file, R0 hardwired to zero, two combinational reads, one synchronous write
module mips_register_file (
    input logic                  clk,
    input logic                  reset,
    mips_register_file_if.slave  bus
);
    logic [31:1] w_we;
    logic [31:0] w_words [0:31];
    assign w_words[0] = 32'h0;
    genvar g;
    for (g = 1; g < 32; g++) begin : g_reg
        logic [31:0] r_q;
        assign w_we[g] = bus.reg_write && (bus.write_reg == 5'(g));
        // reset clears the entry and overrides any write in the same cycle
        always_ff @(posedge clk) begin
            if (reset)
                r_q <= 32'h0;
            else if (w_we[g])
                r_q <= bus.write_data;
        end
        assign w_words[g] = r_q;
    end
    assign bus.read_data1 = w_words[bus.read_reg1];
    assign bus.read_data2 = w_words[bus.read_reg2];
endmodule

// File: tb/tb_mips_register_file.sv
// tb_mips_register_file: directed plan plus randomized traffic against an array model
module tb_mips_register_file;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] m [0:31];
    mips_register_file_if bus ();
    mips_register_file dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rs, input logic we, input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        reset = rs;
        bus.reg_write = we;
        bus.write_reg = a;
        bus.write_data = d;
        @(posedge clk);
        #1;
        if (rs)
            for (int i = 0; i < 32; i++) m[i] = 32'h0;
        else if (we && a != 5'd0)
            m[a] = d;
        reset = 1'b0;
        bus.reg_write = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] a1, input logic [4:0] a2);
        bus.read_reg1 = a1;
        bus.read_reg2 = a2;
        #1;
        check({tag, "_p1"}, bus.read_data1, (a1 == 5'd0) ? 32'h0 : m[a1]);
        check({tag, "_p2"}, bus.read_data2, (a2 == 5'd0) ? 32'h0 : m[a2]);
    endtask

    initial begin
        reset = 1'b1;
        bus.reg_write = 1'b0;
        bus.write_reg = 5'd0;
        bus.write_data = 32'h0;
        bus.read_reg1 = 5'd0;
        bus.read_reg2 = 5'd0;
        step(1'b1, 1'b0, 5'd0, 32'h0);
        rd("init", 5'd3, 5'd31);
        for (int i = 1; i < 32; i++) step(1'b0, 1'b1, 5'(i), 32'hFFFFFFFF);
        rd("prefill", 5'd1, 5'd31);
        step(1'b1, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 32; i++) begin
            rd("rst_clear", 5'(i), 5'(31 - i));
            check("rst_zero", bus.read_data1 | bus.read_data2, 32'h0);
        end
        for (int i = 1; i < 32; i++) step(1'b0, 1'b1, 5'(i), 32'hA5A50000 + 32'(i));
        for (int i = 0; i < 32; i++) begin
            rd("wr_all", 5'(i), 5'(31 - i));
            check("wr_all_const", bus.read_data1, (i == 0) ? 32'h0 : 32'hA5A50000 + 32'(i));
        end
        step(1'b0, 1'b1, 5'd0, 32'hDEADBEEF);
        rd("r0", 5'd0, 5'd0);
        check("r0_const", bus.read_data1 | bus.read_data2, 32'h0);
        for (int i = 1; i < 32; i++) rd("r0_others", 5'(i), 5'(i));
        step(1'b0, 1'b1, 5'd5, 32'h12345678);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 5'd5, 32'h0);
        rd("we_low", 5'd5, 5'd5);
        check("we_low_const", bus.read_data1, 32'h12345678);
        step(1'b0, 1'b1, 5'd7, 32'h00000011);
        @(negedge clk);
        bus.read_reg1 = 5'd7;
        bus.write_reg = 5'd7;
        bus.write_data = 32'h00000022;
        bus.reg_write = 1'b1;
        #1;
        check("rdw_before", bus.read_data1, 32'h00000011);
        @(posedge clk);
        #1;
        check("rdw_after", bus.read_data1, 32'h00000022);
        m[7] = 32'h00000022;
        bus.reg_write = 1'b0;
        step(1'b0, 1'b1, 5'd9, 32'hCAFEF00D);
        rd("r9_pre", 5'd9, 5'd8);
        step(1'b1, 1'b1, 5'd9, 32'h11111111);
        rd("rst_prio", 5'd9, 5'd7);
        check("rst_prio_const", bus.read_data1, 32'h0);
        step(1'b0, 1'b1, 5'd9, 32'h11111111);
        rd("post_rst", 5'd9, 5'd9);
        check("post_rst_const", bus.read_data2, 32'h11111111);
        step(1'b0, 1'b1, 5'd12, 32'h1);
        step(1'b0, 1'b1, 5'd12, 32'h2);
        rd("b2b", 5'd12, 5'd11);
        check("b2b_const", bus.read_data1, 32'h2);
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 24) == 0, 1'($urandom), 5'($urandom), $urandom);
            rd("rand", 5'($urandom), 5'($urandom));
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
